// File: rtl/pes_clkmon_pkg.sv
// Shared types and defaults for the divided-clock monitor.
// Optional synchroniser enabled by defining PES_CLKMON_SYNC_EN.
package pes_clkmon_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StMeas,
        StDone
    } state_e;

    localparam int unsigned DEF_CW       = 8;
    localparam int unsigned DEF_NPER     = 4;
    localparam int unsigned DEF_LOCK_CNT = 2;
    localparam int unsigned MIN_RATIO    = 2;

endpackage

// File: rtl/pes_clkmon_edge.sv
// Samples div_clk into the clkin domain and flags its rising edges.
// PES_CLKMON_SYNC_EN adds a 2-flop synchroniser ahead of the sampling flop.
module pes_clkmon_edge (
    input  logic clkin,
    input  logic rst_n,
    input  logic div_clk,
    output logic s,
    output logic rise
);

    logic s_in;
    logic s_q;
    logic s_d_q;

`ifdef PES_CLKMON_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], div_clk};
        end
    end

    assign s_in = sync_q[1];
`else
    assign s_in = div_clk;
`endif

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= 1'b0;
            s_d_q <= 1'b0;
        end else begin
            s_q   <= s_in;
            s_d_q <= s_q;
        end
    end

    assign s    = s_q;
    assign rise = s_q & ~s_d_q;

endmodule

// File: rtl/pes_clkmon.sv
// Divided-clock monitor: measures period/high time of div_clk over NPER periods,
// compares against exp_n and tracks lock. PES_CLKMON_SYNC_EN selects a synchronised input.
module pes_clkmon
    import pes_clkmon_pkg::*;
#(
    parameter int unsigned CW       = DEF_CW,
    parameter int unsigned NPER     = DEF_NPER,
    parameter int unsigned LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic          clkin,
    input  logic          rst_n,
    input  logic          en,
    input  logic          start,
    input  logic          div_clk,
    input  logic [3:0]    exp_n,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_time,
    output logic          busy,
    output logic          done,
    output logic          match,
    output logic          err_timeout,
    output logic          locked
);

    localparam int unsigned PW = (NPER > 1) ? $clog2(NPER) : 1;
    localparam int unsigned LW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] CMAX  = '1;
    localparam logic [PW-1:0] PLAST = PW'(NPER - 1);
    localparam logic [LW-1:0] LMAX  = LW'(LOCK_CNT);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [PW-1:0] pidx_q, pidx_d;
    logic          mism_q, mism_d;
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] high_q, high_d;
    logic          match_q, match_d;
    logic          err_q, err_d;
    logic [LW-1:0] lock_q, lock_d;

    logic          s;
    logic          rise;
    logic          cnt_eq;
    logic          ratio_ok;
    logic          mism_next;
    logic          match_next;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] hcnt_inc;

    pes_clkmon_edge u_edge (
        .clkin   (clkin),
        .rst_n   (rst_n),
        .div_clk (div_clk),
        .s       (s),
        .rise    (rise)
    );

    assign cnt_eq   = (32'(cnt_q) == 32'(exp_n));
    assign ratio_ok = (exp_n >= 4'(MIN_RATIO));
    assign cnt_inc  = (cnt_q == CMAX) ? cnt_q : cnt_q + CW'(1);
    assign hcnt_inc = (s && hcnt_q != CMAX) ? hcnt_q + CW'(1) : hcnt_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hcnt_d     = hcnt_q;
        pidx_d     = pidx_q;
        mism_d     = mism_q;
        period_d   = period_q;
        high_d     = high_q;
        match_d    = match_q;
        err_d      = err_q;
        lock_d     = lock_q;
        mism_next  = mism_q | ~cnt_eq;
        match_next = ~mism_next & ratio_ok;

        unique case (state_q)
            StIdle: begin
                if (start && en) begin
                    state_d = StArm;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    hcnt_d  = '0;
                    pidx_d  = '0;
                    mism_d  = 1'b0;
                end
            end
            StArm: begin
                if (cnt_q == CMAX) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    lock_d  = '0;
                end else if (rise) begin
                    state_d = StMeas;
                    cnt_d   = CW'(1);
                    hcnt_d  = CW'(1);
                    pidx_d  = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StMeas: begin
                if (cnt_q == CMAX) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    lock_d  = '0;
                end else if (rise) begin
                    period_d = cnt_q;
                    high_d   = hcnt_q;
                    mism_d   = mism_next;
                    cnt_d    = CW'(1);
                    hcnt_d   = CW'(1);
                    if (pidx_q == PLAST) begin
                        // Result registered on entry so it is valid alongside the done pulse
                        state_d = StDone;
                        match_d = match_next;
                        if (match_next) begin
                            lock_d = (lock_q == LMAX) ? lock_q : lock_q + LW'(1);
                        end else begin
                            lock_d = '0;
                        end
                    end else begin
                        pidx_d = pidx_q + PW'(1);
                    end
                end else begin
                    cnt_d  = cnt_inc;
                    hcnt_d = hcnt_inc;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Disable aborts from any state; reported results are left untouched
        if (!en) begin
            state_d  = StIdle;
            lock_d   = '0;
            period_d = period_q;
            high_d   = high_q;
            match_d  = match_q;
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            pidx_q   <= '0;
            mism_q   <= 1'b0;
            period_q <= '0;
            high_q   <= '0;
            match_q  <= 1'b0;
            err_q    <= 1'b0;
            lock_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            pidx_q   <= pidx_d;
            mism_q   <= mism_d;
            period_q <= period_d;
            high_q   <= high_d;
            match_q  <= match_d;
            err_q    <= err_d;
            lock_q   <= lock_d;
        end
    end

    assign period      = period_q;
    assign high_time   = high_q;
    assign busy        = (state_q == StArm) || (state_q == StMeas);
    assign done        = (state_q == StDone);
    assign match       = match_q;
    assign err_timeout = err_q;
    assign locked      = (lock_q == LMAX);

endmodule
